// File: rtl/wb_regfile.sv
// RV32I write-back register file: x1..x31 storage, two combinational source
// ports with optional write-through, a handshaked debug read port and a commit counter.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  input  logic [DATA_WIDTH-1:0] mem_wb_wdata,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  output logic [DATA_WIDTH-1:0] id_rs1_data,
  output logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic                  dbg_req,
  input  logic [4:0]            dbg_addr,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [31:0]           wb_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [DATA_WIDTH-1:0] regs [1:31];
  logic                  commit;
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [DATA_WIDTH-1:0] dbg_value;

  // x0 is hardwired, so a write addressed to it is neither stored nor counted.
  assign commit = mem_wb_reg_write && (mem_wb_rd != 5'd0);

  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [4:0] idx);
    logic [DATA_WIDTH-1:0] value;
    if (idx == 5'd0) begin
      value = '0;
    end else if (BYPASS_EN && commit && (mem_wb_rd == idx)) begin
      value = mem_wb_wdata;
    end else begin
      value = regs[idx];
    end
    return value;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[mem_wb_rd] <= mem_wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= 32'd0;
    end else if (commit) begin
      wb_count <= wb_count + 32'd1;
    end
  end

  always_comb begin
    id_rs1_data = read_value(id_rs1);
    id_rs2_data = read_value(id_rs2);
    dbg_value   = read_value(dbg_addr);
  end

  // ACK always falls back to IDLE, so a held request acks every other cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (dbg_req) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
    end else if ((state == ST_IDLE) && dbg_req) begin
      dbg_rdata <= dbg_value;
    end
  end

  // Decoded from the state flop so reset removes the ack without waiting for an edge.
  assign dbg_ack = (state == ST_ACK);

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a bypassing and a non-bypassing instance
// share stimulus and are compared against a reference model of the register file.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic [31:0] mem_wb_wdata;
  logic [4:0]  id_rs1, id_rs2;
  logic        dbg_req;
  logic [4:0]  dbg_addr;

  logic [31:0] rs1_data, rs2_data, dbg_rdata, wb_count;
  logic        dbg_ack;
  logic [31:0] rs1_data_nb, rs2_data_nb, dbg_rdata_nb, wb_count_nb;
  logic        dbg_ack_nb;

  typedef struct packed {
    logic [31:0] bp;
    logic [31:0] nb;
  } dbg_exp_t;

  dbg_exp_t    exp_q[$];
  logic [31:0] model [32];
  logic [31:0] m_count;
  logic        m_state;
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_cnt = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_WIDTH(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_wdata(mem_wb_wdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(rs1_data), .id_rs2_data(rs2_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .wb_count(wb_count)
  );

  wb_regfile #(.DATA_WIDTH(32), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_wdata(mem_wb_wdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(rs1_data_nb), .id_rs2_data(rs2_data_nb),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack_nb), .dbg_rdata(dbg_rdata_nb),
    .wb_count(wb_count_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit bp);
    logic [31:0] v;
    if (idx == 5'd0) v = 32'd0;
    else if (bp && mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == idx)) v = mem_wb_wdata;
    else v = model[idx];
    return v;
  endfunction

  // Reference model: captures debug expectations and applies commits at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      m_count = 32'd0;
      m_state = 1'b0;
      exp_q.delete();
    end else begin
      if (!m_state && dbg_req) begin
        exp_q.push_back('{bp: model_read(dbg_addr, 1'b1), nb: model_read(dbg_addr, 1'b0)});
        m_state = 1'b1;
      end else begin
        m_state = 1'b0;
      end
      if (mem_wb_reg_write && (mem_wb_rd != 5'd0)) begin
        model[mem_wb_rd] = mem_wb_wdata;
        m_count = m_count + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (dbg_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("dbg_unexpected_ack", 32'd1, 32'd0);
      end else begin
        dbg_exp_t e;
        e = exp_q.pop_front();
        check("dbg_rdata", dbg_rdata, e.bp);
        check("dbg_rdata_nb", dbg_rdata_nb, e.nb);
        check("dbg_ack_nb", {31'd0, dbg_ack_nb}, 32'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    mem_wb_rd = rd;
    mem_wb_reg_write = 1'b1;
    mem_wb_wdata = data;
    cyc();
    mem_wb_reg_write = 1'b0;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_rs1"}, rs1_data, model_read(id_rs1, 1'b1));
    check({tag, "_rs2"}, rs2_data, model_read(id_rs2, 1'b1));
    check({tag, "_rs1_nb"}, rs1_data_nb, model_read(id_rs1, 1'b0));
    check({tag, "_rs2_nb"}, rs2_data_nb, model_read(id_rs2, 1'b0));
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b0; mem_wb_wdata = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; dbg_req = 1'b0; dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: every register reads zero.
    for (int i = 0; i < 32; i++) begin
      id_rs1 = 5'(i);
      id_rs2 = 5'(31 - i);
      @(negedge clk);
      check("rst_rs1", rs1_data, 32'd0);
      check("rst_rs2", rs2_data, 32'd0);
      check("rst_rs1_nb", rs1_data_nb, 32'd0);
    end
    check("rst_count", wb_count, 32'd0);
    check("rst_ack", {31'd0, dbg_ack}, 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    cyc();

    // Write / readback and x0 write.
    write_reg(5'd5, 32'hDEADBEEF);
    id_rs1 = 5'd5;
    @(negedge clk);
    check("wr_x5", rs1_data, 32'hDEADBEEF);
    check("wr_x5_nb", rs1_data_nb, 32'hDEADBEEF);
    cyc();
    write_reg(5'd0, 32'h00001234);
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    check("wr_x0_rs1", rs1_data, 32'd0);
    check("wr_x0_rs2", rs2_data, 32'd0);
    check("wr_count", wb_count, 32'd1);
    cyc();

    // Bypass: same-cycle commit visible only on the bypassing instance.
    write_reg(5'd7, 32'h11111111);
    mem_wb_rd = 5'd7; mem_wb_reg_write = 1'b1; mem_wb_wdata = 32'hA5A5A5A5;
    id_rs1 = 5'd7; id_rs2 = 5'd7;
    @(negedge clk);
    check("byp_rs1", rs1_data, 32'hA5A5A5A5);
    check("byp_rs2", rs2_data, 32'hA5A5A5A5);
    check("byp_rs1_nb", rs1_data_nb, 32'h11111111);
    check("byp_rs2_nb", rs2_data_nb, 32'h11111111);
    cyc();
    mem_wb_rd = 5'd0; mem_wb_wdata = 32'hFFFF0000;
    @(negedge clk);
    check("byp_x0_write", rs1_data, 32'hA5A5A5A5);
    check("byp_after_nb", rs1_data_nb, 32'hA5A5A5A5);
    cyc();
    mem_wb_reg_write = 1'b0;

    // Debug single pulse.
    write_reg(5'd3, 32'h00000055);
    dbg_addr = 5'd3; dbg_req = 1'b1;
    cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    check("dbg_ack_hi", {31'd0, dbg_ack}, 32'd1);
    check("dbg_rdata_55", dbg_rdata, 32'h55);
    cyc();
    @(negedge clk);
    check("dbg_ack_lo", {31'd0, dbg_ack}, 32'd0);
    check("dbg_rdata_hold", dbg_rdata, 32'h55);
    cyc();

    // Debug read of a register being committed in the same cycle.
    dbg_addr = 5'd4; dbg_req = 1'b1;
    mem_wb_rd = 5'd4; mem_wb_reg_write = 1'b1; mem_wb_wdata = 32'h00000077;
    cyc();
    dbg_req = 1'b0; mem_wb_reg_write = 1'b0;
    repeat (2) cyc();

    // Held request: one ack every two cycles.
    a0 = ack_cnt;
    dbg_addr = 5'd5; dbg_req = 1'b1;
    repeat (6) cyc();
    dbg_req = 1'b0;
    repeat (2) cyc();
    check("dbg_held_acks", 32'(ack_cnt - a0), 32'd3);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      mem_wb_rd = 5'($urandom_range(0, 31));
      mem_wb_reg_write = 1'($urandom_range(0, 1));
      mem_wb_wdata = $urandom;
      id_rs1 = ($urandom_range(0, 3) == 0) ? mem_wb_rd : 5'($urandom_range(0, 31));
      id_rs2 = ($urandom_range(0, 3) == 0) ? id_rs1 : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 1) == 0) ? mem_wb_rd : 5'($urandom_range(0, 31));
      dbg_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_ports("rnd");
      check("rnd_count", wb_count, m_count);
      check("rnd_count_nb", wb_count_nb, m_count);
      cyc();
    end
    mem_wb_reg_write = 1'b0; dbg_req = 1'b0;
    repeat (2) cyc();

    // Reset asserted during an ACK cycle.
    write_reg(5'd9, 32'h000000FF);
    dbg_addr = 5'd9; dbg_req = 1'b1;
    cyc();
    dbg_req = 1'b0;
    check("mid_ack_before", {31'd0, dbg_ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_ack_async", {31'd0, dbg_ack}, 32'd0);
    check("mid_ack_async_nb", {31'd0, dbg_ack_nb}, 32'd0);
    check("mid_count", wb_count, 32'd0);
    id_rs1 = 5'd9; id_rs2 = 5'd9;
    #1;
    check("mid_x9", rs1_data, 32'd0);
    cyc();
    rst_n = 1'b1;
    a0 = ack_cnt;
    @(negedge clk);
    check("post_x9", rs2_data, 32'd0);
    check("post_count", wb_count, 32'd0);
    repeat (3) cyc();
    check("post_no_ack", 32'(ack_cnt - a0), 32'd0);

    // Counter wrap via deposit.
    @(negedge clk);
    force dut.wb_count = 32'hFFFFFFFF;
    #1 release dut.wb_count;
    #1 check("wrap_deposit", wb_count, 32'hFFFFFFFF);
    cyc();
    write_reg(5'd2, 32'h2);
    @(negedge clk);
    check("wrap_zero", wb_count, 32'd0);
    cyc();

    check("dbg_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back-side register file for the RV32I pipeline: consumes the MEM/WB destination register (`mem_wb_rd`), write enable and write data, and serves the two ID-stage source operands. It is the receiving end of the `mem_wb_rd` signal that the MEM/WB stage drives. It also provides a handshaked debug read port and a committed-write counter for the UVM scoreboard.

## Interface
- `DATA_WIDTH`, 32: register width in bits.
- `BYPASS_EN`, 1: 1 makes a same-cycle write visible on the read ports (write-through); 0 makes reads return stored contents only.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; the polarity and synchronicity of reset are fixed.
- `mem_wb_rd`  in  5  destination register index from MEM/WB.
- `mem_wb_reg_write`  in  1  write enable from MEM/WB.
- `mem_wb_wdata`  in  DATA_WIDTH  write-back data.
- `id_rs1`, `id_rs2`  in  5 each  ID-stage source indices.
- `id_rs1_data`, `id_rs2_data`  out  DATA_WIDTH each  source operands, combinational.
- `dbg_req`  in  1  debug read request.
- `dbg_addr`  in  5  debug read index.
- `dbg_ack`  out  1  one-cycle pulse: `dbg_rdata` valid.
- `dbg_rdata`  out  DATA_WIDTH  debug read data, registered.
- `wb_count`  out  32  number of committed writes, registered.

## Operation
- Storage: 31 registers x1..x31. x0 is not stored and always reads 0.
- Commit condition: `mem_wb_reg_write`=1 and `mem_wb_rd`!=0, at a rising `clk` edge.
  - A commit writes `mem_wb_wdata` to `mem_wb_rd`.
  - A commit increments `wb_count` by 1, wrapping from 0xFFFFFFFF to 0.
  - A write to x0 changes nothing and is not counted.
- Read port rsN:
  - `id_rsN`=0 gives 0.
  - Otherwise, if `BYPASS_EN`=1, the commit condition is true this cycle and `mem_wb_rd`=`id_rsN`, the port gives `mem_wb_wdata`.
  - Otherwise the port gives the stored value.
  - Both ports may address the same register; both must return identical data.
- Debug FSM, two states:
  - IDLE: `dbg_ack`=0. If `dbg_req`=1 at an edge, capture the read value of `dbg_addr` and go to ACK. The read value uses the same rules as the read ports, including bypass.
  - ACK: `dbg_ack`=1 for exactly this one cycle, then unconditionally return to IDLE. `dbg_req` sampled in ACK is ignored.
  - Consequence: a held `dbg_req` produces one ack every two cycles.
  - `dbg_rdata` holds its last captured value until the next capture.
- Reset (async assert, synchronous release by next edge):
  - All registers clear to 0, so both read ports return 0.
  - `wb_count`=0, `dbg_ack`=0, `dbg_rdata`=0, FSM=IDLE.
  - Reset asserted while in ACK drops `dbg_ack` immediately. No ack is issued after release unless a new request arrives.

## Timing
- Read ports: zero latency, combinational from `id_rs*`, stored state and the bypass inputs.
- Writes: state is updated at the edge. With `BYPASS_EN`=0 a written value is first visible in the cycle after the commit edge.
- Debug: request sampled at edge N; `dbg_ack` and `dbg_rdata` are valid during the cycle after edge N and drop at edge N+1.
- `wb_count` reflects a commit in the cycle after the commit edge.
- The block performs no hazard stalling. It sits at the ID/WB boundary and has no other pipeline latency.

## Test plan
- Reset then read all: after `rst_n` release, sweep `id_rs1`/`id_rs2` over 0..31 -> every read 0, `wb_count`=0, `dbg_ack`=0.
- Write/readback: commit rd=5, wdata=0xDEADBEEF; next cycle `id_rs1`=5 -> 0xDEADBEEF. Commit rd=0, wdata=0x1234 -> x0 reads 0, `wb_count` increments once in total.
- Bypass: same cycle commit rd=7, wdata=0xA5A5A5A5 with `id_rs1`=`id_rs2`=7 -> both ports 0xA5A5A5A5 in that cycle with `BYPASS_EN`=1; old value with `BYPASS_EN`=0.
- Debug handshake: x3=0x55 stored; pulse `dbg_req` with addr 3 -> `dbg_ack` high exactly one cycle with `dbg_rdata`=0x55. Hold `dbg_req` high for 6 cycles -> exactly 3 acks.
- Reset mid-operation: assert `rst_n`=0 during the ACK cycle and after writing x9=0xFF -> `dbg_ack` falls asynchronously, x9 reads 0, `wb_count`=0.
- Counter wrap: force `wb_count` to 0xFFFFFFFF via hierarchical deposit, then one valid commit -> `wb_count`=0.
